// File: rtl/sample_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sample_capture_pkg
// Description : Shared types and constants for the sample capture engine.
//               - state_t      : capture FSM state encoding
//               - DEFAULT_DIV  : divider value used after reset and when a
//                                zero divider is requested
//               - depth_of()   : block length derived from address width
// Revision    : 1.0 - initial release
// ============================================================================
package sample_capture_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  localparam int DEFAULT_DIV = 1;

  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sample_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : sample_prescaler
// Description : Sample-rate prescaler. Counts 0..D-1 while enabled and wraps;
//               o_tick is asserted whenever enabled with the count at 0, so
//               the first tick lands on the first enabled cycle after clear.
// Ports       : iClock    - clock
//               iReset    - synchronous active-high reset
//               i_clear   - force count to 0
//               i_enable  - advance count / allow tick
//               i_divider - latched divider D (never 0)
//               o_tick    - sample tick (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module sample_prescaler #(
  parameter int DIV_W = 16
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [DIV_W-1:0] i_divider,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_count;
  logic             w_wrap;

  assign w_wrap = (r_count == (i_divider - DIV_W'(1)));
  assign o_tick = i_enable && (r_count == '0);

  always_ff @(posedge iClock) begin
    if (iReset || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_wrap ? '0 : (r_count + DIV_W'(1));
    end
  end

endmodule
`default_nettype wire

// File: rtl/sample_capture.sv
`default_nettype none
// ============================================================================
// Module      : sample_capture
// Description : Block capture engine. On an accepted start it writes 2**ADDR_W
//               samples of iData to a memory write port, one every iDivider
//               clocks, then pulses oDone for one cycle. All outputs are
//               registered (oArmed is tied low without the trigger option).
// Option      : SAMPLE_CAPTURE_TRIGGER_EN - when defined, an accepted start
//               arms the engine and capture begins on a rising iTrigger.
// Ports       : iClock, iReset (sync, active-high)
//               iStart   - start request, accepted only in IDLE
//               iDivider - sample period in clocks (0 treated as 1)
//               iTrigger - capture trigger (option only)
//               iData    - sampled bus
//               oWrEn/oWrAddr/oWrData - memory write port
//               oBusy, oArmed, oDone  - status
// Revision    : 1.0 - initial release
// ============================================================================
module sample_capture
  import sample_capture_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iStart,
  input  logic [DIV_W-1:0]  iDivider,
  input  logic              iTrigger,
  input  logic [DATA_W-1:0] iData,
  output logic              oWrEn,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic [DATA_W-1:0] oWrData,
  output logic              oBusy,
  output logic              oArmed,
  output logic              oDone
);

  localparam int                DEPTH     = depth_of(ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [DIV_W-1:0]  r_div;
  logic [ADDR_W-1:0] r_addr;
  logic              w_tick;
  logic              w_accept;   // start accepted this edge
  logic              w_go;       // capture begins this edge
  logic              w_clear;

`ifdef SAMPLE_CAPTURE_TRIGGER_EN
  logic r_trig_prev;
  logic r_armed;
  logic w_trig_rise;

  // History is tracked in every state so a trigger that is already high
  // when the engine arms must fall and rise again before it counts.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_trig_prev <= 1'b0;
    end else begin
      r_trig_prev <= iTrigger;
    end
  end

  assign w_trig_rise = iTrigger && !r_trig_prev;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_armed <= 1'b0;
    end else if (w_go) begin
      r_armed <= 1'b0;
    end else if (w_accept) begin
      r_armed <= 1'b1;
    end
  end

  assign oArmed = r_armed;
`else
  logic w_unused_trig;
  assign w_unused_trig = iTrigger;
  assign oArmed        = 1'b0;
`endif

  assign w_clear = w_accept || w_go;

  sample_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .iClock    (iClock),
    .iReset    (iReset),
    .i_clear   (w_clear),
    .i_enable  (r_state == S_CAPTURE),
    .i_divider (r_div),
    .o_tick    (w_tick)
  );

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_go         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (iStart) begin
          w_accept = 1'b1;
`ifdef SAMPLE_CAPTURE_TRIGGER_EN
          w_state_next = S_ARMED;
`else
          w_go         = 1'b1;
          w_state_next = S_CAPTURE;
`endif
        end
      end
`ifdef SAMPLE_CAPTURE_TRIGGER_EN
      S_ARMED: begin
        if (w_trig_rise) begin
          w_go         = 1'b1;
          w_state_next = S_CAPTURE;
        end
      end
`endif
      S_CAPTURE: begin
        if (w_tick && (r_addr == LAST_ADDR)) begin
          w_state_next = S_FINISH;
        end
      end
      S_FINISH: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_div   <= DIV_W'(DEFAULT_DIV);
      r_addr  <= '0;
      oWrEn   <= 1'b0;
      oWrAddr <= '0;
      oWrData <= '0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
    end else begin
      oWrEn <= 1'b0;
      oDone <= 1'b0;
      if (w_accept) begin
        r_div <= (iDivider == '0) ? DIV_W'(DEFAULT_DIV) : iDivider;
        oBusy <= 1'b1;
      end
      if (w_clear) begin
        r_addr <= '0;
      end
      if ((r_state == S_CAPTURE) && w_tick) begin
        oWrEn   <= 1'b1;
        oWrAddr <= r_addr;
        oWrData <= iData;
        // Natural wrap to 0 after the last address of the block.
        r_addr  <= r_addr + ADDR_W'(1);
      end
      if (r_state == S_FINISH) begin
        oDone <= 1'b1;
        oBusy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/sample_capture.md
# sample_capture

Capture engine that sits directly downstream of the main controller FSM. On a start pulse it records a block of `2**ADDR_W` samples of the circuit-under-test output bus at a programmable clock-divided rate. It writes each sample to the sample memory through a write port and returns a one-cycle done pulse, which the controller consumes as its sampling-done input. All outputs are registered.

## Interface
- `DATA_W`, 8: sample width.
- `ADDR_W`, 8: sample memory address width; block length `DEPTH = 2**ADDR_W`.
- `DIV_W`, 16: divider width.

- `iClock`  in  1  clock.
- `iReset`  in  1  reset, synchronous, active-high.
- `iStart`  in  1  start request (controller's start-sampling pulse); level-sampled each edge.
- `iDivider`  in  DIV_W  sample period in clocks; latched on accepted start; 0 treated as 1.
- `iTrigger`  in  1  capture trigger (used only with `SAMPLE_CAPTURE_TRIGGER_EN`).
- `iData`  in  DATA_W  bus being sampled.
- `oWrEn`  out  1  memory write strobe, one cycle per sample.
- `oWrAddr`  out  ADDR_W  write address.
- `oWrData`  out  DATA_W  write data.
- `oBusy`  out  1  capture in progress.
- `oArmed`  out  1  waiting for trigger (0 when macro absent).
- `oDone`  out  1  one-cycle completion pulse.

## Operation
- States: `IDLE`, `ARMED` (macro only), `CAPTURE`, `FINISH`.
- `IDLE`, `iStart`=1:
  - latch divider (`max(iDivider,1)`), clear address and prescaler, set `oBusy`.
  - go to `ARMED` (macro) or `CAPTURE`.
- `iStart` ignored outside `IDLE`; `iDivider` changes after latch have no effect.
- `CAPTURE` prescaler:
  - counts 0..D-1 and wraps; tick when prescaler==0.
  - on a tick: `oWrEn`<=1, `oWrData`<=`iData`, `oWrAddr`<=address, address increments.
- Tick with address==DEPTH-1 is the last write (address wraps to 0); state goes to `FINISH`.
- `FINISH`: `oDone`<=1, `oBusy`<=0, state goes to `IDLE`. `oDone` is high exactly one cycle.
- `oWrEn` is low in all non-tick cycles; `oWrAddr`/`oWrData` hold their last values.
- Reset values: all outputs 0, state `IDLE`, address 0, prescaler 0, latched divider 1.
- Reset mid-capture: immediate return to `IDLE`; no further writes; no `oDone`.
- `iStart` in the `FINISH` cycle is ignored. `iStart` in the `oDone` cycle (state already `IDLE`) is accepted: back-to-back blocks.

## Timing
- Let edge N be the edge at which `iStart` is accepted (or the trigger edge, with the macro).
- `oBusy` rises after edge N.
- Write k (k=0..DEPTH-1):
  - `oWrEn` high in the cycle after edge N+1+k·D.
  - `oWrData` = `iData` sampled at that edge; `oWrAddr` = k.
- `oDone` is high after edge N+2+(DEPTH-1)·D. `oBusy` falls at the same edge.
- Total latency from start to done: 2+(DEPTH-1)·D edges.

## Configuration
- `SAMPLE_CAPTURE_TRIGGER_EN` defined:
  - accepted start enters `ARMED` with `oArmed`=1.
  - capture begins at the first edge where `iTrigger`=1 and the registered previous `iTrigger`=0. That edge is edge N.
  - A trigger already high at start must fall and rise again.
  - `oArmed` clears at edge N.
- Undefined: no `ARMED` state, no trigger history register, `iTrigger` unused, `oArmed` tied 0, capture begins at the start edge.

## Structure
- Package `sample_capture_pkg` holds:
  - state enum;
  - default-divider constant (1);
  - `DEPTH` derivation helper.
- Sub-module `sample_prescaler`:
  - inputs: clear, enable, latched divider.
  - output: tick pulse.
  - instantiated once.

## Test plan
- `ADDR_W`=2, `iDivider`=1, `iData` incrementing from 0x10 each clock, start at edge N → `oWrEn` after edges N+1..N+4 with addr 0..3; `oDone` after N+5 only.
- `iDivider`=3 → writes spaced 3 cycles apart at addr 0..3; `oDone` after edge N+11.
- `iDivider`=0 → identical to divider 1; `iStart` held high during capture → no restart, exactly 4 writes.
- `iReset` asserted after second write → all outputs 0 next cycle, no `oDone`, new start recaptures from addr 0.
- Start reasserted in the `oDone` cycle → second block begins; addresses restart at 0.
- Macro on: `iTrigger` high before start, falls, rises 5 cycles later → `oArmed`=1 until the rising edge; first write after that edge+1.
